// File: rtl/cpu32_pkg.sv
// Shared constants and types for the cpu32 register file.
// Provides data/address widths, the word and register-address types,
// and the soft-clear FSM state encoding.
package cpu32_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = $clog2(NREGS);

    typedef logic [XLEN-1:0] word_t;
    typedef logic [AW-1:0]   raddr_t;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

endpackage : cpu32_pkg

// File: rtl/reg_word.sv
// One XLEN-bit storage word with write enable and synchronous active-low reset.
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset (clears the word)
//   en     in   load enable
//   d      in   load data
//   q      out  stored word
module reg_word
    import cpu32_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  word_t d,
    output word_t q
);

    word_t val_q;
    word_t val_d;

    // Next-value select
    always_comb begin
        val_d = val_q;
        if (en) begin
            val_d = d;
        end
    end

    // Storage flop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q = val_q;

endmodule : reg_word

// File: rtl/reg_file.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous
// write port, R0 reads as zero, plus a sequential soft-clear sweep that
// zeroes one entry per cycle.
// Ports:
//   clk      in   clock, all state updates on rising edge
//   rst_n    in   synchronous active-low reset
//   we       in   write enable (ignored while clearing)
//   waddr    in   write address
//   wdata    in   write data
//   raddr_a  in   read port A address
//   rdata_a  out  read port A data (combinational)
//   raddr_b  in   read port B address
//   rdata_b  out  read port B data (combinational)
//   clr_req  in   start soft-clear (ignored while clearing)
//   clr_busy out  high while soft-clear is in progress (registered)
// Configuration:
//   REGFILE_BYPASS_EN  when defined, a same-cycle write to the address being
//                      read is forwarded to that read port.
module reg_file
    import cpu32_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   we,
    input  raddr_t waddr,
    input  word_t  wdata,
    input  raddr_t raddr_a,
    output word_t  rdata_a,
    input  raddr_t raddr_b,
    output word_t  rdata_b,
    input  logic   clr_req,
    output logic   clr_busy
);

    localparam raddr_t LAST_PTR = raddr_t'(NREGS - 1);

    rf_state_e state_q;
    rf_state_e state_d;
    raddr_t    ptr_q;
    raddr_t    ptr_d;
    logic      busy_q;
    logic      busy_d;

    logic      wr_en;
    logic      clr_en;
    word_t     words [NREGS];

    // Clear FSM next-state, pointer and busy flag
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    ptr_d   = raddr_t'(1);
                    busy_d  = 1'b1;
                end
            end
            RF_CLEAR: begin
                if (ptr_q == LAST_PTR) begin
                    state_d = RF_IDLE;
                    ptr_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    ptr_d   = ptr_q + raddr_t'(1);
                end
            end
            default: begin
                state_d = RF_IDLE;
                ptr_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RF_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign clr_busy = busy_q;

    // Writes are only honoured in IDLE; R0 writes are dropped here.
    assign wr_en  = we && (state_q == RF_IDLE) && (waddr != '0);
    assign clr_en = (state_q == RF_CLEAR);

    // R0 has no storage
    assign words[0] = '0;

    // Storage words R1..R(NREGS-1); write and clear hits are mutually
    // exclusive because they depend on disjoint FSM states.
    for (genvar i = 1; i < NREGS; i++) begin : g_word
        logic  hit_wr;
        logic  hit_clr;
        word_t load_val;

        assign hit_wr   = wr_en  && (waddr == raddr_t'(i));
        assign hit_clr  = clr_en && (ptr_q == raddr_t'(i));
        assign load_val = hit_clr ? word_t'(0) : wdata;

        reg_word u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (hit_wr | hit_clr),
            .d     (load_val),
            .q     (words[i])
        );
    end

    // Read port A
    always_comb begin
        rdata_a = words[raddr_a];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end
`endif
    end

    // Read port B
    always_comb begin
        rdata_b = words[raddr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end
`endif
    end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized
// traffic compared against an array-based behavioural model.
module tb_reg_file;

    localparam int NR = 32;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [31:0] rdata_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_b;
    logic        clr_req;
    logic        clr_busy;

    int n_checks;
    int n_errors;

    // Behavioural model: register contents, sweep active flag, next index to zero
    logic [31:0] m_mem [NR];
    bit          m_busy;
    int          m_idx;

    reg_file dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (raddr_a),
        .rdata_a  (rdata_a),
        .raddr_b  (raddr_b),
        .rdata_b  (rdata_b),
        .clr_req  (clr_req),
        .clr_busy (clr_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int addr);
        if (addr == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && !m_busy && (int'(waddr) == addr)) return wdata;
`endif
        return m_mem[addr];
    endfunction

    // Apply the model's rules for one rising edge, then advance past it.
    task automatic step();
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) m_mem[i] = 32'h0;
            m_busy = 1'b0;
            m_idx  = 0;
        end else if (!m_busy) begin
            if (we && waddr != 5'd0) m_mem[waddr] = wdata;
            if (clr_req) begin
                m_busy = 1'b1;
                m_idx  = 1;
            end
        end else begin
            m_mem[m_idx] = 32'h0;
            if (m_idx == NR - 1) m_busy = 1'b0;
            else m_idx++;
        end
        @(posedge clk);
        #1;
    endtask

    // Compare both read ports and busy flag against the model.
    task automatic probe(input string tag);
        #1;
        chk({tag, "_a"}, rdata_a, model_read(int'(raddr_a)));
        chk({tag, "_b"}, rdata_b, model_read(int'(raddr_b)));
        chk({tag, "_busy"}, {31'h0, clr_busy}, {31'h0, m_busy});
    endtask

    task automatic write_reg(input int a, input logic [31:0] d);
        we = 1'b1; waddr = 5'(a); wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < NR; i++) begin
            raddr_a = 5'(i);
            raddr_b = 5'(NR - 1 - i);
            #1;
            chk({tag, "_a"}, rdata_a, 32'h0);
            chk({tag, "_b"}, rdata_b, 32'h0);
        end
    endtask

    initial begin
        int busy_cycles;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < NR; i++) m_mem[i] = 32'hx;
        m_busy = 1'b0; m_idx = 0;
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0; clr_req = 1'b0;

        // 1. Reset
        step(); step();
        rst_n = 1'b1;
        check_all_zero("reset");
        chk("reset_busy", {31'h0, clr_busy}, 32'h0);

        // 2. Basic write/read
        write_reg(5, 32'hDEADBEEF);
        raddr_a = 5'd5; raddr_b = 5'd6;
        #1;
        chk("wr_r5", rdata_a, 32'hDEADBEEF);
        chk("wr_r6", rdata_b, 32'h0);

        // 3. R0 is hard-wired zero
        write_reg(0, 32'hFFFFFFFF);
        raddr_a = 5'd0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("r0_zero", rdata_a, 32'h0);
            step();
        end

        // 4. Same-cycle read/write
        write_reg(7, 32'h11111111);
        we = 1'b1; waddr = 5'd7; wdata = 32'h22222222; raddr_a = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("rw_same", rdata_a, 32'h22222222);
`else
        chk("rw_same", rdata_a, 32'h11111111);
`endif
        step();
        we = 1'b0;
        #1;
        chk("rw_after", rdata_a, 32'h22222222);

        // 5. Soft clear with a dropped mid-sweep write
        for (int i = 1; i < NR; i++) write_reg(i, 32'(i));
        raddr_a = 5'd17; raddr_b = 5'd31;
        #1;
        chk("fill_r17", rdata_a, 32'd17);
        chk("fill_r31", rdata_b, 32'd31);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        busy_cycles = 0;
        while (clr_busy && busy_cycles < 100) begin
            busy_cycles++;
            we = (busy_cycles == 5);
            waddr = 5'd3; wdata = 32'hAA;
            raddr_a = 5'($urandom_range(0, NR - 1));
            raddr_b = 5'($urandom_range(0, NR - 1));
            probe("sweep");
            step();
        end
        we = 1'b0;
        chk("busy_len", 32'(busy_cycles), 32'd31);
        chk("busy_end", {31'h0, clr_busy}, 32'h0);
        check_all_zero("cleared");

        // 6. Reset mid-clear
        for (int i = 1; i < NR; i++) write_reg(i, $urandom);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 9; k++) step();
        chk("midclr_busy", {31'h0, clr_busy}, 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midclr_rst_busy", {31'h0, clr_busy}, 32'h0);
        check_all_zero("midclr_rst");

        // 7. Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            we      = ($urandom_range(0, 3) != 0);
            waddr   = 5'($urandom_range(0, NR - 1));
            wdata   = $urandom;
            raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, NR - 1));
            raddr_b = 5'($urandom_range(0, NR - 1));
            clr_req = ($urandom_range(0, 59) == 0);
            rst_n   = ($urandom_range(0, 199) != 0);
            probe("rand");
            step();
        end
        rst_n = 1'b1; we = 1'b0; clr_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_reg_file
